// File: rtl/conv_window_sched_pkg.sv
// Shared types and sizing helpers for the convolution window sequencer.
// The state enum, default geometry and a clog2 used to size the select and address buses.
package conv_window_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT,
        DONE
    } state_t;

    localparam int IMG_W_DEF = 28;
    localparam int KER_W_DEF = 21;
    localparam int RES_W_DEF = 24;

    // Bits needed to index v distinct values; never less than 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/conv_window_sched_if.sv
// Control, row-select, engine handshake and result stream of the window sequencer.
// master = sequencer side, slave = engine / result store / host side.
interface conv_window_sched_if
    import conv_window_sched_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int KER_W = KER_W_DEF,
    parameter int RES_W = RES_W_DEF
);
    localparam int OUT_W = IMG_W - KER_W + 1;
    localparam int RC_W  = clog2(IMG_W);
    localparam int OA_W  = clog2(OUT_W * OUT_W);

    logic             start;
    logic             busy;
    logic             done;
    logic             row_valid;
    logic [RC_W-1:0]  img_row;
    logic [RC_W-1:0]  img_col;
    logic [RC_W-1:0]  ker_row;
    logic             conv_start;
    logic             conv_done;
    logic [RES_W-1:0] conv_result;
    logic             out_valid;
    logic             out_ready;
    logic [OA_W-1:0]  out_addr;
    logic [RES_W-1:0] out_data;
    logic             err;

    modport master (
        input  start, conv_done, conv_result, out_ready,
        output busy, done, row_valid, img_row, img_col, ker_row,
               conv_start, out_valid, out_addr, out_data, err
    );

    modport slave (
        output start, conv_done, conv_result, out_ready,
        input  busy, done, row_valid, img_row, img_col, ker_row,
               conv_start, out_valid, out_addr, out_data, err
    );

endinterface

// File: rtl/conv_window_sched_pos_counter.sv
// Nested output-position counter: column runs fastest, row steps on column wrap.
// last flags the final (OUT_W-1, OUT_W-1) position; advancing from it returns to (0,0).
module conv_window_sched_pos_counter #(
    parameter int OUT_W = 8,
    parameter int RC_W  = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            advance,
    output logic [RC_W-1:0] out_row,
    output logic [RC_W-1:0] out_col,
    output logic            last
);
    logic wrap;

    assign wrap = (out_col == RC_W'(OUT_W - 1));
    assign last = wrap && (out_row == RC_W'(OUT_W - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_row <= '0;
            out_col <= '0;
        end else if (clear) begin
            out_row <= '0;
            out_col <= '0;
        end else if (advance) begin
            if (last) begin
                out_row <= '0;
                out_col <= '0;
            end else if (wrap) begin
                out_row <= out_row + 1'b1;
                out_col <= '0;
            end else begin
                out_col <= out_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_window_sched.sv
// Walks every stride-1 output position, issues KER_W row selects per position,
// waits on the engine, then hands one addressed result to the downstream store.
module conv_window_sched
    import conv_window_sched_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int KER_W = KER_W_DEF,
    parameter int RES_W = RES_W_DEF
) (
    input logic                 clk,
    input logic                 reset,
    conv_window_sched_if.master bus
);
    localparam int OUT_W = IMG_W - KER_W + 1;
    localparam int RC_W  = clog2(IMG_W);
    localparam int OA_W  = clog2(OUT_W * OUT_W);

    state_t           state, nxt;
    logic [RC_W-1:0]  k;
    logic [RC_W-1:0]  out_row, out_col;
    logic             pos_last;
    logic             k_last, start_acc, hs, cap;
    logic             row_valid, conv_start, out_valid;
    logic             busy_q, done_q, err_q;
    logic [RES_W-1:0] data_q;

    assign k_last    = (k == RC_W'(KER_W - 1));
    assign start_acc = (state == IDLE) && bus.start;
    assign hs        = (state == OUT) && bus.out_ready;
    assign cap       = (state == WAIT) && bus.conv_done;

    conv_window_sched_pos_counter #(
        .OUT_W (OUT_W),
        .RC_W  (RC_W)
    ) u_pos (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_acc),
        .advance (hs),
        .out_row (out_row),
        .out_col (out_col),
        .last    (pos_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt        = state;
        row_valid  = 1'b0;
        conv_start = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE:  if (bus.start) nxt = ISSUE;
            ISSUE: begin
                row_valid  = 1'b1;
                conv_start = 1'b1;
                if (k_last) nxt = WAIT;
            end
            WAIT: begin
                conv_start = 1'b1;
                if (bus.conv_done) nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (bus.out_ready) nxt = pos_last ? DONE : ISSUE;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // k wraps to 0 on the last row so the next position always starts at kernel row 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)               k <= '0;
        else if (start_acc)      k <= '0;
        else if (state == ISSUE) k <= k_last ? '0 : k + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_acc) begin
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (hs && pos_last) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
        end
    end

    // A stray conv_done anywhere but WAIT is flagged and never captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  err_q <= 1'b0;
        else if (start_acc)                         err_q <= 1'b0;
        else if (bus.conv_done && state != WAIT)   err_q <= 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    data_q <= '0;
        else if (cap) data_q <= bus.conv_result;
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.row_valid  = row_valid;
    assign bus.conv_start = conv_start;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = data_q;
    assign bus.img_row    = row_valid ? out_row + k : '0;
    assign bus.img_col    = row_valid ? out_col : '0;
    assign bus.ker_row    = row_valid ? k : '0;
    assign bus.out_addr   = out_valid ? OA_W'(out_row) * OA_W'(OUT_W) + OA_W'(out_col) : '0;

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench: a 4x4/3x3 instance for the handshake corners, a default 28/21 instance
// for the full 64-position sweep. Engine models return 100*row + col two cycles after the last row.
`timescale 1ns/1ps
module tb_conv_window_sched;

    localparam int KA = 3;
    localparam int KB = 21;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    conv_window_sched_if #(.IMG_W(4), .KER_W(3), .RES_W(24)) a ();
    conv_window_sched_if b ();

    conv_window_sched #(.IMG_W(4), .KER_W(3), .RES_W(24)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a)
    );

    conv_window_sched dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    logic        ea_done, fa_done, eb_done;
    logic [23:0] ea_res, eb_res;
    assign a.conv_done   = ea_done | fa_done;
    assign a.conv_result = ea_res;
    assign b.conv_done   = eb_done;
    assign b.conv_result = eb_res;

    int got_addr [8];
    int got_data [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_a(input int i);
        return 100 * (i / 2) + (i % 2);
    endfunction

    // Engine model, small instance.
    initial begin
        int r, c;
        ea_done = 1'b0;
        ea_res  = '0;
        forever begin
            @(negedge clk);
            if (a.row_valid && int'(a.ker_row) == KA - 1) begin
                r = int'(a.img_row) - (KA - 1);
                c = int'(a.img_col);
                repeat (2) @(negedge clk);
                ea_done = 1'b1;
                ea_res  = 24'(100 * r + c);
                @(negedge clk);
                ea_done = 1'b0;
            end
        end
    end

    // Engine model, default instance.
    initial begin
        int r, c;
        eb_done = 1'b0;
        eb_res  = '0;
        forever begin
            @(negedge clk);
            if (b.row_valid && int'(b.ker_row) == KB - 1) begin
                r = int'(b.img_row) - (KB - 1);
                c = int'(b.img_col);
                repeat (2) @(negedge clk);
                eb_done = 1'b1;
                eb_res  = 24'(100 * r + c);
                @(negedge clk);
                eb_done = 1'b0;
            end
        end
    end

    task automatic start_a();
        @(negedge clk);
        a.start = 1'b1;
        @(negedge clk);
        a.start = 1'b0;
    endtask

    // Runs the small instance until done; optional output stall and an optional poke
    // (stray start, or forced conv_done) during the ISSUE of position poke_at.
    task automatic run_a(input int stall_at, input int stall_len, input int poke_at,
                         input bit poke_force, output int cnt);
        bit poked;
        int cyc;
        poked = 1'b0;
        cyc   = 0;
        cnt   = 0;
        a.out_ready = 1'b1;
        while (!a.done && cyc < 500) begin
            @(negedge clk);
            cyc++;
            a.start = 1'b0;
            fa_done = 1'b0;
            if (!poked && cnt == poke_at && a.row_valid) begin
                poked = 1'b1;
                if (poke_force) fa_done = 1'b1;
                else            a.start = 1'b1;
            end
            if (a.out_valid) begin
                if (cnt < 8) begin
                    got_addr[cnt] = int'(a.out_addr);
                    got_data[cnt] = int'(a.out_data);
                end
                if (cnt == stall_at) begin
                    a.out_ready = 1'b0;
                    for (int i = 0; i < stall_len; i++) begin
                        @(negedge clk);
                        cyc++;
                        chk("stall_valid", 32'(a.out_valid), 32'd1);
                        chk("stall_addr", 32'(a.out_addr), 32'(stall_at));
                        chk("stall_data", 32'(a.out_data), 32'(exp_a(stall_at)));
                        chk("stall_rowv", 32'(a.row_valid), 32'd0);
                    end
                    a.out_ready = 1'b1;
                end
                cnt++;
            end
        end
        a.start = 1'b0;
        fa_done = 1'b0;
        chk("pass_timeout", 32'(cyc < 500), 32'd1);
    endtask

    task automatic chk_stream(input string tag, input int cnt);
        chk({tag, "_cnt"}, 32'(cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_addr"}, 32'(got_addr[i]), 32'(i));
            chk({tag, "_data"}, 32'(got_data[i]), 32'(exp_a(i)));
        end
    endtask

    initial begin
        int  cnt;
        int  cyc;
        int  max_row;
        int  last_addr;
        int  last_data;
        bit  found;

        reset       = 1'b1;
        a.start     = 1'b0;
        a.out_ready = 1'b0;
        b.start     = 1'b0;
        b.out_ready = 1'b0;
        fa_done     = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_busy", 32'(a.busy), 32'd0);
        chk("rst_done", 32'(a.done), 32'd0);
        chk("rst_rowv", 32'(a.row_valid), 32'd0);
        chk("rst_cstart", 32'(a.conv_start), 32'd0);
        chk("rst_ovalid", 32'(a.out_valid), 32'd0);
        chk("rst_addr", 32'(a.out_addr), 32'd0);
        chk("rst_data", 32'(a.out_data), 32'd0);
        chk("rst_err", 32'(a.err), 32'd0);
        reset = 1'b0;

        // 1: basic pass, row sequence of the first position.
        start_a();
        chk("t1_busy", 32'(a.busy), 32'd1);
        for (int kk = 0; kk < KA; kk++) begin
            if (kk > 0) @(negedge clk);
            chk("t1_rowv", 32'(a.row_valid), 32'd1);
            chk("t1_img_row", 32'(a.img_row), 32'(kk));
            chk("t1_ker_row", 32'(a.ker_row), 32'(kk));
            chk("t1_img_col", 32'(a.img_col), 32'd0);
        end
        run_a(-1, 0, -1, 1'b0, cnt);
        chk_stream("t1", cnt);
        chk("t1_done", 32'(a.done), 32'd1);
        chk("t1_busy_end", 32'(a.busy), 32'd0);
        @(negedge clk);
        chk("t1_done_sticky", 32'(a.done), 32'd1);

        // 2: 10-cycle stall on the second result.
        start_a();
        chk("t2_done_clr", 32'(a.done), 32'd0);
        run_a(1, 10, -1, 1'b0, cnt);
        chk_stream("t2", cnt);

        // 3: start pulsed mid-pass is ignored.
        start_a();
        run_a(-1, 0, 1, 1'b0, cnt);
        chk_stream("t3", cnt);
        chk("t3_err", 32'(a.err), 32'd0);

        // 4: stray conv_done during ISSUE flags err without disturbing the stream.
        start_a();
        run_a(-1, 0, 2, 1'b1, cnt);
        chk_stream("t4", cnt);
        chk("t4_err", 32'(a.err), 32'd1);
        start_a();
        chk("t4_err_clr", 32'(a.err), 32'd0);
        run_a(-1, 0, -1, 1'b0, cnt);
        chk("t4_rerun_cnt", 32'(cnt), 32'd4);

        // 5: reset in WAIT of the third position, then replay from address 0.
        start_a();
        a.out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (a.row_valid && int'(a.ker_row) == KA - 1 && int'(a.img_row) == 3 &&
                int'(a.img_col) == 0)
                found = 1'b1;
        end
        chk("t5_found", 32'(found), 32'd1);
        @(negedge clk);
        chk("t5_in_wait", 32'(a.conv_start && !a.row_valid), 32'd1);
        chk("t5_data_pre", 32'(a.out_data), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t5_busy", 32'(a.busy), 32'd0);
        chk("t5_cstart", 32'(a.conv_start), 32'd0);
        chk("t5_ovalid", 32'(a.out_valid), 32'd0);
        chk("t5_data", 32'(a.out_data), 32'd0);
        chk("t5_rowv", 32'(a.row_valid), 32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        chk("t5_err", 32'(a.err), 32'd0);
        start_a();
        run_a(-1, 0, -1, 1'b0, cnt);
        chk_stream("t5", cnt);

        // 6: default geometry, full 8x8 sweep.
        @(negedge clk);
        b.start = 1'b1;
        @(negedge clk);
        b.start     = 1'b0;
        b.out_ready = 1'b1;
        cnt       = 0;
        cyc       = 0;
        max_row   = 0;
        last_addr = -1;
        last_data = -1;
        while (!b.done && cyc < 5000) begin
            if (b.row_valid && int'(b.img_row) > max_row) max_row = int'(b.img_row);
            if (b.out_valid) begin
                chk("t6_addr", 32'(b.out_addr), 32'(cnt));
                chk("t6_data", 32'(b.out_data), 32'(100 * (cnt / 8) + cnt % 8));
                last_addr = int'(b.out_addr);
                last_data = int'(b.out_data);
                cnt++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("t6_timeout", 32'(cyc < 5000), 32'd1);
        chk("t6_cnt", 32'(cnt), 32'd64);
        chk("t6_last_addr", 32'(last_addr), 32'd63);
        chk("t6_last_data", 32'(last_data), 32'd707);
        chk("t6_max_img_row", 32'(max_row), 32'd27);
        chk("t6_done", 32'(b.done), 32'd1);
        chk("t6_busy", 32'(b.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
